// File: rtl/lane_serializer.sv
// Parallel-to-serial lane serializer: captures a group of up to LANES bytes and
// emits the valid lanes one per clock in ascending lane order with ready/valid handshaking.
module lane_serializer #(
   parameter int LANES     = 4,
   parameter int WIDTH     = 8,
   parameter int LANE_BITS = $clog2(LANES)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [LANES*WIDTH-1:0] in_data,
   input  logic [LANES-1:0]       in_valid,
   input  logic                   in_push,
   output logic                   in_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic [LANE_BITS-1:0]   out_lane,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_last,
   output logic                   ovf
);

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   state_t                 state;
   logic [LANES*WIDTH-1:0] hold_data;
   logic [LANES-1:0]       hold_mask;
   logic [LANES-1:0]       mask_rest;
   logic [LANE_BITS-1:0]   cur_lane;
   logic [WIDTH-1:0]       cur_data;
   logic                   one_left;
   logic                   accept;
   logic                   load;

   // Priority encoder on the registered mask; scanning downward lets the lowest set bit win.
   always_comb begin
      cur_lane = '0;
      cur_data = hold_data[WIDTH-1:0];
      for (int i = LANES - 1; i >= 0; i--) begin
         if (hold_mask[i]) begin
            cur_lane = LANE_BITS'(i);
            cur_data = hold_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Clearing the lowest set bit doubles as the "exactly one lane left" test.
   assign mask_rest = hold_mask & (hold_mask - LANES'(1));
   assign one_left  = (hold_mask != '0) && (mask_rest == '0);

   assign out_valid = (state == SEND);
   assign out_last  = (state == SEND) && one_left;
   assign out_data  = cur_data;
   assign out_lane  = cur_lane;
   assign in_ready  = (state == IDLE) || (out_last && out_ready);
   assign accept    = in_push && in_ready;
   assign load      = accept && (in_valid != '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         hold_data <= '0;
         hold_mask <= '0;
         ovf       <= 1'b0;
      end else begin
         if (in_push && !in_ready) begin
            ovf <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (load) begin
                  hold_data <= in_data;
                  hold_mask <= in_valid;
                  state     <= SEND;
               end
            end
            SEND: begin
               if (out_ready) begin
                  if (!one_left) begin
                     hold_mask <= mask_rest;
                  end else if (load) begin
                     hold_data <= in_data;
                     hold_mask <= in_valid;
                  end else begin
                     hold_mask <= '0;
                     state     <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lane_serializer.sv
// Directed self-checking bench for lane_serializer with LANES=4, WIDTH=8.
module tb_lane_serializer;

   logic        clk;
   logic        reset;
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic        in_push;
   logic        in_ready;
   logic [7:0]  out_data;
   logic [1:0]  out_lane;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        ovf;

   int n_checks = 0;
   int n_fail   = 0;

   lane_serializer #(.LANES(4), .WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_push   (in_push),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_lane  (out_lane),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every scenario starts and ends 1 time unit after a rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; in_push = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_valid: got %b expected 0", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_in_ready: got %b expected 1", in_ready); end
      n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_ovf: got %b expected 0", ovf); end
      n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("[TB] FAIL rst_data: got %h expected 00", out_data); end
      n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_last: got %b expected 0", out_last); end
      n_checks++; if (out_lane !== 2'd0) begin n_fail++; $display("[TB] FAIL rst_lane: got %0d expected 0", out_lane); end
      reset = 1'b1;
      step();
      step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL post_rst_valid: got %b expected 0", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL post_rst_in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_full_group();
      logic [7:0] exp_data [4];
      exp_data = '{8'hFF, 8'hEE, 8'hDD, 8'hCC};
      in_data = 32'hCCDDEEFF; in_valid = 4'b1111; in_push = 1'b1; out_ready = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL full_accept: got %b expected 1", in_ready); end
      step();
      in_push = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL full_valid[%0d]: got %b expected 1", i, out_valid); end
         n_checks++; if (out_data !== exp_data[i]) begin n_fail++; $display("[TB] FAIL full_data[%0d]: got %h expected %h", i, out_data, exp_data[i]); end
         n_checks++; if (out_lane !== 2'(i)) begin n_fail++; $display("[TB] FAIL full_lane[%0d]: got %0d expected %0d", i, out_lane, i); end
         n_checks++; if (out_last !== (i == 3)) begin n_fail++; $display("[TB] FAIL full_last[%0d]: got %b expected %b", i, out_last, (i == 3)); end
         n_checks++; if (in_ready !== (i == 3)) begin n_fail++; $display("[TB] FAIL full_in_ready[%0d]: got %b expected %b", i, in_ready, (i == 3)); end
         step();
      end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL full_end_valid: got %b expected 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      in_data = 32'h8899AABB; in_valid = 4'b1010; in_push = 1'b1; out_ready = 1'b1;
      step();
      in_push = 1'b0;
      #1;
      n_checks++; if (out_data !== 8'hAA || out_lane !== 2'd1) begin n_fail++; $display("[TB] FAIL sparse_beat0: got %h/%0d expected aa/1", out_data, out_lane); end
      n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("[TB] FAIL sparse_last0: got %b expected 0", out_last); end
      step();
      in_data = 32'h00770000; in_valid = 4'b0100; in_push = 1'b1;
      #1;
      n_checks++; if (out_data !== 8'h88 || out_lane !== 2'd3) begin n_fail++; $display("[TB] FAIL sparse_beat1: got %h/%0d expected 88/3", out_data, out_lane); end
      n_checks++; if (out_last !== 1'b1) begin n_fail++; $display("[TB] FAIL sparse_last1: got %b expected 1", out_last); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_in_ready: got %b expected 1", in_ready); end
      step();
      in_push = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_valid: got %b expected 1", out_valid); end
      n_checks++; if (out_data !== 8'h77 || out_lane !== 2'd2) begin n_fail++; $display("[TB] FAIL b2b_beat: got %h/%0d expected 77/2", out_data, out_lane); end
      n_checks++; if (out_last !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_last: got %b expected 1", out_last); end
      step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_end_valid: got %b expected 0", out_valid); end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp_data [7];
      logic       exp_ready [7];
      int         busy;
      exp_data  = '{8'hFF, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hDD, 8'hCC};
      exp_ready = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      busy = 0;
      in_data = 32'hCCDDEEFF; in_valid = 4'b1111; in_push = 1'b1; out_ready = 1'b1;
      step();
      in_push = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i < 7) out_ready = exp_ready[i];
         else       out_ready = 1'b1;
         #1;
         if (out_valid === 1'b1) busy++;
         if (i < 7) begin
            n_checks++; if (out_data !== exp_data[i]) begin n_fail++; $display("[TB] FAIL bp_data[%0d]: got %h expected %h", i, out_data, exp_data[i]); end
         end
         if (i >= 1 && i <= 3) begin
            n_checks++; if (in_ready !== 1'b0 || out_lane !== 2'd1) begin n_fail++; $display("[TB] FAIL bp_stall[%0d]: in_ready %b lane %0d expected 0/1", i, in_ready, out_lane); end
         end
         step();
      end
      n_checks++; if (busy != 7) begin n_fail++; $display("[TB] FAIL bp_length: got %0d expected 7", busy); end
   endtask

   task automatic test_overflow();
      logic [7:0] exp_data [3];
      exp_data = '{8'hEE, 8'hDD, 8'hCC};
      in_data = 32'hCCDDEEFF; in_valid = 4'b1111; in_push = 1'b1; out_ready = 1'b1;
      step();
      in_data = 32'h44332211; in_valid = 4'b1111; in_push = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b0 || out_data !== 8'hFF) begin n_fail++; $display("[TB] FAIL ovf_push: in_ready %b data %h expected 0/ff", in_ready, out_data); end
      step();
      in_push = 1'b0;
      n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_set: got %b expected 1", ovf); end
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++; if (out_valid !== 1'b1 || out_data !== exp_data[i]) begin n_fail++; $display("[TB] FAIL ovf_stream[%0d]: got %b/%h expected 1/%h", i, out_valid, out_data, exp_data[i]); end
         step();
      end
      n_checks++; if (out_valid !== 1'b0 || ovf !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_sticky: valid %b ovf %b expected 0/1", out_valid, ovf); end
      in_data = 32'h12345678; in_valid = 4'b0000; in_push = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL empty_ready: got %b expected 1", in_ready); end
      step();
      in_push = 1'b0;
      n_checks++; if (out_valid !== 1'b0 || ovf !== 1'b1) begin n_fail++; $display("[TB] FAIL empty_push: valid %b ovf %b expected 0/1", out_valid, ovf); end
      step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL empty_later: got %b expected 0", out_valid); end
   endtask

   task automatic test_reset_mid_group();
      logic [7:0] exp_data [4];
      exp_data = '{8'h11, 8'h22, 8'h33, 8'h44};
      in_data = 32'hCCDDEEFF; in_valid = 4'b1111; in_push = 1'b1; out_ready = 1'b1;
      step();
      in_push = 1'b0;
      step();
      step();
      n_checks++; if (out_data !== 8'hDD || out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_pre: got %b/%h expected 1/dd", out_valid, out_data); end
      #2;
      reset = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_async: valid %b last %b expected 0/0", out_valid, out_last); end
      n_checks++; if (ovf !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_ovf: ovf %b in_ready %b expected 0/1", ovf, in_ready); end
      step();
      reset = 1'b1;
      step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_no_beat: got %b expected 0", out_valid); end
      in_data = 32'h44332211; in_valid = 4'b1111; in_push = 1'b1;
      step();
      in_push = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++; if (out_valid !== 1'b1 || out_data !== exp_data[i] || out_lane !== 2'(i)) begin
            n_fail++; $display("[TB] FAIL after_rst[%0d]: got %b/%h/%0d expected 1/%h/%0d", i, out_valid, out_data, out_lane, exp_data[i], i);
         end
         step();
      end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL after_rst_end: got %b expected 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_full_group();
      test_back_to_back();
      test_backpressure();
      test_overflow();
      test_reset_mid_group();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
